mult_signed_seq: RTL and testbench
==================================

MULT_SIGNED_SEQ -- requirements
Module: mult_signed_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a multiply; sampled on the rising clk edge.
REQ-006 Port: is_signed  input  1  operand mode: 1 = two's-complement signed, 0 = unsigned; sampled with start.
REQ-007 Port: a  input  WIDTH  multiplicand; sampled with start.
REQ-008 Port: b  input  WIDTH  multiplier; sampled with start.
REQ-009 Port: busy  output  1  high while a multiply is in progress.
REQ-010 Port: done  output  1  single-cycle pulse when product is updated.
REQ-011 Port: product  output  2*WIDTH  full-width result; signed or unsigned per the captured mode.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 State transitions SHALL be:
- IDLE -> RUN when start=1.
- RUN -> DONE after exactly WIDTH RUN cycles.
- DONE -> RUN when start=1.
- DONE -> IDLE when start=0.
REQ-014 On acceptance of start, the block SHALL latch a, b and is_signed into internal registers; input changes after that edge SHALL NOT affect the result.
REQ-015 RUN SHALL process one multiplier bit per cycle (iterative shift-add, or radix-2 Booth in signed mode), for WIDTH iterations.
REQ-016 Latency: if start is accepted at edge k, done SHALL be 1 and product SHALL be valid in the cycle following edge k+WIDTH+1.
REQ-017 busy SHALL be 1 exactly in RUN.
REQ-018 done SHALL be 1 exactly in DONE, for one cycle.
REQ-019 start while busy=1 SHALL be ignored: no restart, no effect on the result in progress.
REQ-020 start asserted during DONE SHALL be accepted: back-to-back operation with no IDLE gap, so busy rises on the next cycle.
REQ-021 product SHALL change only on the edge entering DONE; it SHALL hold its value through IDLE and RUN until the next completion.
REQ-022 Signed mode: product SHALL equal the exact two's-complement product of a and b over 2*WIDTH bits, with no overflow or saturation, including (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-023 Unsigned mode: product SHALL equal the exact unsigned product of zero-extended a and b, e.g. (2^WIDTH-1)^2.
REQ-024 Zero operands SHALL run the full WIDTH cycles, with no early termination, so latency is data-independent.
REQ-025 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done and product SHALL all be 0 after that edge.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst during RUN or DONE SHALL abort the operation: no done pulse SHALL follow, and product SHALL read 0.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=16 unless stated; clock edges counted from the start-accept edge k):
- Signed corner: is_signed=1, a=-32768, b=-32768 -> done at edge k+17, product=1073741824 (0x40000000); 100 random signed pairs over all four sign quadrants match a*b.
- Mode contrast: a=b=16'hFFFF. With is_signed=1 -> product=1. With is_signed=0 -> product=32'hFFFE0001.
- Busy protection: start a=3, b=-5; during RUN, re-assert start with a=7, b=7 and change the inputs -> one done pulse only, product=-15, busy stays high for exactly 16 cycles.
- Back-to-back: start held high through DONE with new operands a=-1, b=12345 -> first result is delivered, busy re-asserts the next cycle, second done is 17 edges after the first, product=-12345.
- Reset mid-operation: rst=1 at the 8th RUN cycle -> busy=0, done=0, product=0 next cycle; no done follows; a fresh start then completes correctly.
- Parameter check: WIDTH=8, is_signed=1, a=-128, b=127 -> product=-16256 after 9 edges; unsigned 255*255 -> 65025.

Source files
------------

// File: rtl/mult_signed_seq.sv
// mult_signed_seq: iterative shift-add multiplier, signed or unsigned, one multiplier bit per cycle
module mult_signed_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sgn_q, sgn_d, busy_q, busy_d, done_q, done_d;
    logic               accept, last;
    logic [2*WIDTH-1:0] term;

    // Next-state and datapath: the multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so its partial product is subtracted
    always_comb begin
        accept    = start && (state_q != RUN);
        last      = cnt_q == CW'(WIDTH - 1);
        term      = mplier_q[0] ? mcand_q : '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        sgn_d     = sgn_q;
        if (state_q == RUN) begin
            acc_d    = (last && sgn_q) ? acc_q - term : acc_q + term;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            state_d  = last ? DONE : RUN;
        end
        if (accept) begin
            state_d  = RUN;
            sgn_d    = is_signed;
            mcand_d  = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == DONE) begin
            state_d  = IDLE;
        end
        busy_d    = state_q == RUN;
        done_d    = state_q == DONE;
        product_d = (state_q == DONE) ? acc_q : product_q;
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            sgn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            sgn_q     <= sgn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_mult_signed_seq.sv
// tb_mult_signed_seq: random and directed checks of mult_signed_seq against a timeline model
module tb_mult_signed_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, start, is_signed, busy, done;
    logic [15:0] a, b;
    logic [31:0] product;
    logic start8, sgn8, busy8, done8;
    logic [7:0] a8, b8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mult_signed_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    mult_signed_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref16(input bit s, input logic [15:0] x, input logic [15:0] y);
        longint sx, sy, p;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        p = sx * sy;
        return p[31:0];
    endfunction

    // Timeline model: an accepted op at edge acc_e shows busy after edges acc_e+1..acc_e+W and done after acc_e+W+1
    longint e = 0, acc_e = 0, n_e;
    bit have = 0, in_run, fin;
    logic [31:0] pend = '0, m_prod = '0;
    logic m_busy = 0, m_done = 0;

    always @(posedge clk) begin
        n_e = e + 1;
        in_run = have && n_e > acc_e && n_e <= acc_e + W;
        fin = have && n_e == acc_e + W + 1;
        e <= n_e;
        if (rst) begin
            have <= 0;
            m_busy <= 0;
            m_done <= 0;
            m_prod <= '0;
        end else begin
            m_busy <= in_run;
            m_done <= fin;
            if (fin) m_prod <= pend;
            if (start && !in_run) begin
                have <= 1;
                acc_e <= n_e;
                pend <= ref16(is_signed, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("product", product, m_prod);
        end
    end

    task automatic go(input bit s, input logic [15:0] x, input logic [15:0] y);
        start = 1; is_signed = s; a = x; b = y;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check({nm, "_latency"}, n, 17);
        check(nm, product, exp);
    endtask

    initial begin
        int n, nb, nd;
        logic [15:0] ra, rb;
        rst = 1; start = 0; is_signed = 0; a = '0; b = '0;
        start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        check("reset_product8", product8, 0);
        chk_en = 1;
        rst = 0;
        @(negedge clk);

        go(1, 16'h8000, 16'h8000);
        wait_done("signed_corner", 32'h40000000);

        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            ra[15] = i[0]; rb[15] = i[1];
            go(1, ra, rb);
            wait_done("random_signed", ref16(1, ra, rb));
        end
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            go(0, ra, rb);
            wait_done("random_unsigned", ref16(0, ra, rb));
        end

        go(1, 16'hFFFF, 16'hFFFF);
        wait_done("mode_signed", 32'h00000001);
        go(0, 16'hFFFF, 16'hFFFF);
        wait_done("mode_unsigned", 32'hFFFE0001);
        go(0, 16'h0000, 16'h1234);
        wait_done("zero_operand", 32'h0);

        go(1, 16'd3, 16'hFFFB);
        nb = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin start = 1; a = 16'd7; b = 16'd7; end
            else if (i == 5) begin start = 0; a = 16'd9; b = 16'd2; end
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        check("protect_busy_cycles", nb, 16);
        check("protect_done_count", nd, 1);
        check("protect_product", product, 32'hFFFFFFF1);

        start = 1; is_signed = 1; a = 16'd6; b = 16'd7;
        @(negedge clk);
        a = 16'hFFFF; b = 16'd12345;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        check("b2b_first_latency", n, 17);
        check("b2b_first_product", product, 32'd42);
        start = 0;
        @(negedge clk);
        check("b2b_busy_next", busy, 1);
        n = 1;
        while (!done && n < 40) begin @(negedge clk); n++; end
        check("b2b_second_gap", n, 17);
        check("b2b_second_product", product, 32'hFFFFCFC7);

        go(1, 16'd100, 16'hFFFD);
        repeat (7) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        rst = 0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        go(1, 16'hFFF9, 16'd9);
        wait_done("after_abort", 32'hFFFFFFC1);

        start8 = 1; sgn8 = 1; a8 = 8'h80; b8 = 8'h7F;
        @(negedge clk);
        start8 = 0;
        repeat (8) @(negedge clk);
        check("w8_done_early", done8, 0);
        @(negedge clk);
        check("w8_signed_done", done8, 1);
        check("w8_signed_product", product8, 16'hC080);
        start8 = 1; sgn8 = 0; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 0;
        repeat (9) @(negedge clk);
        check("w8_unsigned_done", done8, 1);
        check("w8_unsigned_product", product8, 16'hFE01);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
